// File: rtl/irq_ctrl.sv
// irq_ctrl: multi-source external interrupt controller feeding the CP0
// external interrupt input.
//
// The request lines are asynchronous, so each one passes through a
// two-flop synchroniser. A third flop provides rising-edge detection.
// Edge-triggered sources latch events into a pending register. Level
// sources report the synchronised line directly. A software mask selects
// which pending sources are eligible, and the lowest-index eligible source
// is requested. Once CP0 acknowledges the request, the source stays in
// service until ERET. There is no nesting.
//
// Ports
//   clk         main clock
//   rst         synchronous reset, active-high
//   irq_src     raw asynchronous request lines, one per source
//   mask_we     mask register write strobe
//   mask_wdata  new mask value (1 = source enabled)
//   ir_ack      CP0 took the interrupt this cycle
//   eret        CP0 executing ERET this cycle
//   ir_out      interrupt request to CP0
//   ir_id       index of the requested / in-service source
//   mask        current mask register
//   pending     current pending bits
//   in_service  high between ack and ERET
//
// FSM states
//   state      | meaning
//   ST_IDLE    | nothing requested, arbitrating over eligible sources
//   ST_REQ     | ir_out high for ir_id, waiting for ack or withdraw
//   ST_SERVICE | interrupt ir_id acknowledged, waiting for ERET

module irq_ctrl #(
    parameter int unsigned     NSRC      = 8,
    parameter int unsigned     IDW       = 3,
    parameter logic [NSRC-1:0] EDGE_MASK = {NSRC{1'b1}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            ir_ack,
    input  logic            eret,
    output logic            ir_out,
    output logic [IDW-1:0]  ir_id,
    output logic [NSRC-1:0] mask,
    output logic [NSRC-1:0] pending,
    output logic            in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] s1_q, s2_q, s3_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [IDW-1:0]  ir_id_q, ir_id_d;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] pending_all;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] id_onehot;
    logic [NSRC-1:0] ack_clr;
    logic [IDW-1:0]  sel_id;
    logic            cur_eligible;

    assign rise = s2_q & ~s3_q;

    // Level sources bypass the pending register and report the
    // synchronised line, so they clear themselves when the source drops.
    assign pending_all = (pend_q & EDGE_MASK) | (s2_q & ~EDGE_MASK);
    assign eligible    = pending_all & mask_q;

    assign id_onehot    = NSRC'(1) << ir_id_q;
    assign cur_eligible = |(eligible & id_onehot);

    // Lowest-index eligible source. The scan runs from high to low so that
    // the last assignment made is the lowest index.
    always_comb begin
        sel_id = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id = IDW'(i);
            end
        end
    end

    // Only edge sources are cleared by an ack. Any rise in the same cycle
    // is OR'd in afterwards, so a new event is never lost.
    always_comb begin
        ack_clr = '0;
        if (state_q == ST_REQ && ir_ack) begin
            ack_clr = id_onehot & EDGE_MASK;
        end
        pend_d = ((pend_q & ~ack_clr) | rise) & EDGE_MASK;
    end

    always_comb begin
        mask_d = mask_q;
        if (mask_we) begin
            mask_d = mask_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_id_d = ir_id_q;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    ir_id_d = sel_id;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ir_ack) begin
                    state_d = ST_SERVICE;
                end else if (!cur_eligible) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eret) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            ir_id_q <= '0;
        end else begin
            state_q <= state_d;
            s1_q    <= irq_src;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            ir_id_q <= ir_id_d;
        end
    end

    assign ir_out     = (state_q == ST_REQ);
    assign in_service = (state_q == ST_SERVICE);
    assign ir_id      = ir_id_q;
    assign mask       = mask_q;
    assign pending    = pending_all;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq_src = 8'h00;
    logic       mask_we = 1'b0;
    logic [7:0] mask_wdata = 8'h00;
    logic       ir_ack = 1'b0;
    logic       eret = 1'b0;
    logic       ir_out;
    logic [2:0] ir_id;
    logic [7:0] mask;
    logic [7:0] pending;
    logic       in_service;

    int tests = 0;
    int fails = 0;

    irq_ctrl #(.NSRC(8), .IDW(3), .EDGE_MASK(8'hFE)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ir_ack     (ir_ack),
        .eret       (eret),
        .ir_out     (ir_out),
        .ir_id      (ir_id),
        .mask       (mask),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [7:0] v);
        mask_we = 1'b1; mask_wdata = v;
        step(1);
        mask_we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        tests++;
        if ({ir_out, ir_id, mask, pending, in_service} !== 21'd0) begin
            $display("FAIL reset_outputs got ir_out=%b id=%0d mask=%h pend=%h insvc=%b want all 0",
                     ir_out, ir_id, mask, pending, in_service);
            fails++;
        end
    endtask

    task automatic test_mask_gate;
        write_mask(8'h00);
        irq_src[2] = 1'b1;
        step(3);
        irq_src[2] = 1'b0;
        tests++;
        if (pending !== 8'h04) begin $display("FAIL t1_pending got %h want 04", pending); fails++; end
        step(2);
        tests++;
        if (ir_out !== 1'b0) begin $display("FAIL t1_masked_irout got %b want 0", ir_out); fails++; end
        tests++;
        if (pending !== 8'h04) begin $display("FAIL t1_pending_held got %h want 04", pending); fails++; end
        write_mask(8'hFF);
        tests++;
        if (ir_out !== 1'b0) begin $display("FAIL t1_irout_early got %b want 0", ir_out); fails++; end
        step(1);
        tests++;
        if (ir_out !== 1'b1 || ir_id !== 3'd2) begin
            $display("FAIL t1_request got ir_out=%b id=%0d want 1 id 2", ir_out, ir_id); fails++;
        end
    endtask

    task automatic test_ack_eret;
        irq_src[5] = 1'b1;
        step(3);
        irq_src[5] = 1'b0;
        tests++;
        if (pending !== 8'h24 || ir_out !== 1'b1 || ir_id !== 3'd2) begin
            $display("FAIL t2_no_preempt got pend=%h ir_out=%b id=%0d want 24 1 2", pending, ir_out, ir_id); fails++;
        end
        ir_ack = 1'b1;
        step(1);
        ir_ack = 1'b0;
        tests++;
        if (pending !== 8'h20 || in_service !== 1'b1 || ir_out !== 1'b0 || ir_id !== 3'd2) begin
            $display("FAIL t2_ack got pend=%h insvc=%b ir_out=%b id=%0d want 20 1 0 2",
                     pending, in_service, ir_out, ir_id); fails++;
        end
        step(2);
        tests++;
        if (in_service !== 1'b1 || ir_out !== 1'b0) begin
            $display("FAIL t2_no_nesting got insvc=%b ir_out=%b want 1 0", in_service, ir_out); fails++;
        end
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        tests++;
        if (ir_out !== 1'b0 || in_service !== 1'b0) begin
            $display("FAIL t2_eret_idle got ir_out=%b insvc=%b want 0 0", ir_out, in_service); fails++;
        end
        step(1);
        tests++;
        if (ir_out !== 1'b1 || ir_id !== 3'd5) begin
            $display("FAIL t2_rerequest got ir_out=%b id=%0d want 1 id 5", ir_out, ir_id); fails++;
        end
        ir_ack = 1'b1; eret = 1'b1;
        step(1);
        ir_ack = 1'b0; eret = 1'b0;
        tests++;
        if (in_service !== 1'b1 || pending !== 8'h00) begin
            $display("FAIL t2_ack_beats_eret got insvc=%b pend=%h want 1 00", in_service, pending); fails++;
        end
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        step(1);
        tests++;
        if (ir_out !== 1'b0 || pending !== 8'h00) begin
            $display("FAIL t2_quiet got ir_out=%b pend=%h want 0 00", ir_out, pending); fails++;
        end
    endtask

    task automatic test_withdraw;
        irq_src[3] = 1'b1;
        step(3);
        irq_src[3] = 1'b0;
        step(1);
        tests++;
        if (ir_out !== 1'b1 || ir_id !== 3'd3) begin
            $display("FAIL t3_request got ir_out=%b id=%0d want 1 id 3", ir_out, ir_id); fails++;
        end
        write_mask(8'hF7);
        tests++;
        if (ir_out !== 1'b1 || mask !== 8'hF7) begin
            $display("FAIL t3_mask_written got ir_out=%b mask=%h want 1 F7", ir_out, mask); fails++;
        end
        step(1);
        tests++;
        if (ir_out !== 1'b0 || pending !== 8'h08 || in_service !== 1'b0) begin
            $display("FAIL t3_withdraw got ir_out=%b pend=%h insvc=%b want 0 08 0", ir_out, pending, in_service); fails++;
        end
        step(2);
        tests++;
        if (ir_out !== 1'b0) begin $display("FAIL t3_stays_idle got %b want 0", ir_out); fails++; end
        write_mask(8'hFF);
        step(1);
        tests++;
        if (ir_out !== 1'b1 || ir_id !== 3'd3) begin
            $display("FAIL t3_unmask_request got ir_out=%b id=%0d want 1 id 3", ir_out, ir_id); fails++;
        end
        ir_ack = 1'b1;
        step(1);
        ir_ack = 1'b0;
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        step(1);
        tests++;
        if (ir_out !== 1'b0 || pending !== 8'h00) begin
            $display("FAIL t3_cleanup got ir_out=%b pend=%h want 0 00", ir_out, pending); fails++;
        end
    endtask

    task automatic test_set_and_clear;
        irq_src[1] = 1'b1;
        step(3);
        irq_src[1] = 1'b0;
        step(1);
        tests++;
        if (ir_out !== 1'b1 || ir_id !== 3'd1) begin
            $display("FAIL t4_request got ir_out=%b id=%0d want 1 id 1", ir_out, ir_id); fails++;
        end
        step(2);
        irq_src[1] = 1'b1;
        step(2);
        ir_ack = 1'b1;
        step(1);
        ir_ack = 1'b0;
        irq_src[1] = 1'b0;
        tests++;
        if (pending !== 8'h02 || in_service !== 1'b1) begin
            $display("FAIL t4_set_wins got pend=%h insvc=%b want 02 1", pending, in_service); fails++;
        end
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        step(1);
        tests++;
        if (ir_out !== 1'b1 || ir_id !== 3'd1) begin
            $display("FAIL t4_rerequest got ir_out=%b id=%0d want 1 id 1", ir_out, ir_id); fails++;
        end
        ir_ack = 1'b1;
        step(1);
        ir_ack = 1'b0;
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        step(1);
        tests++;
        if (ir_out !== 1'b0 || pending !== 8'h00) begin
            $display("FAIL t4_cleanup got ir_out=%b pend=%h want 0 00", ir_out, pending); fails++;
        end
    endtask

    task automatic test_level;
        irq_src[0] = 1'b1;
        step(2);
        tests++;
        if (pending !== 8'h01 || ir_out !== 1'b0) begin
            $display("FAIL t5_level_pending got pend=%h ir_out=%b want 01 0", pending, ir_out); fails++;
        end
        step(1);
        tests++;
        if (ir_out !== 1'b1 || ir_id !== 3'd0) begin
            $display("FAIL t5_request got ir_out=%b id=%0d want 1 id 0", ir_out, ir_id); fails++;
        end
        ir_ack = 1'b1;
        step(1);
        ir_ack = 1'b0;
        tests++;
        if (pending !== 8'h01 || in_service !== 1'b1) begin
            $display("FAIL t5_ack_no_clear got pend=%h insvc=%b want 01 1", pending, in_service); fails++;
        end
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        step(1);
        tests++;
        if (ir_out !== 1'b1 || ir_id !== 3'd0) begin
            $display("FAIL t5_rerequest got ir_out=%b id=%0d want 1 id 0", ir_out, ir_id); fails++;
        end
        irq_src[0] = 1'b0;
        step(2);
        tests++;
        if (pending !== 8'h00 || ir_out !== 1'b1) begin
            $display("FAIL t5_level_drop got pend=%h ir_out=%b want 00 1", pending, ir_out); fails++;
        end
        step(1);
        tests++;
        if (ir_out !== 1'b0 || in_service !== 1'b0) begin
            $display("FAIL t5_withdraw got ir_out=%b insvc=%b want 0 0", ir_out, in_service); fails++;
        end
    endtask

    task automatic test_reset_in_service;
        irq_src = 8'hFF;
        step(3);
        tests++;
        if (ir_out !== 1'b1 || ir_id !== 3'd0) begin
            $display("FAIL t6_request got ir_out=%b id=%0d want 1 id 0", ir_out, ir_id); fails++;
        end
        ir_ack = 1'b1;
        step(1);
        ir_ack = 1'b0;
        tests++;
        if (in_service !== 1'b1 || pending !== 8'hFF) begin
            $display("FAIL t6_service got insvc=%b pend=%h want 1 FF", in_service, pending); fails++;
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        irq_src = 8'h00;
        tests++;
        if ({ir_out, ir_id, mask, pending, in_service} !== 21'd0) begin
            $display("FAIL t6_reset got ir_out=%b id=%0d mask=%h pend=%h insvc=%b want all 0",
                     ir_out, ir_id, mask, pending, in_service); fails++;
        end
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        step(3);
        tests++;
        if ({ir_out, ir_id, mask, pending, in_service} !== 21'd0) begin
            $display("FAIL t6_eret_ignored got ir_out=%b id=%0d mask=%h pend=%h insvc=%b want all 0",
                     ir_out, ir_id, mask, pending, in_service); fails++;
        end
    endtask

    initial begin
        test_reset();
        test_mask_gate();
        test_ack_eret();
        test_withdraw();
        test_set_and_clear();
        test_level();
        test_reset_in_service();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
